// File: rtl/mem_master_if.sv
// CPU-side request/response and memory-port signals for mem_master.
// The master modport is the bus initiator's view; slave is the CPU/memory side.
interface mem_master_if;
    logic        req;
    logic        we;
    logic        m1;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        busy;
    logic        ack;
    logic [7:0]  rdata;
    logic [6:0]  r_reg;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_rdata;

    modport master (
        input  req, we, m1, addr, wdata, mem_rdata,
        output busy, ack, rdata, r_reg, mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport slave (
        output req, we, m1, addr, wdata, mem_rdata,
        input  busy, ack, rdata, r_reg, mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_master.sv
// Single-transfer bus initiator: IDLE -> T1 -> TW* -> T2 -> DONE, with registered
// outputs, configurable wait states and a 7-bit refresh counter bumped by opcode fetches.
module mem_master #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_master_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_TW,
        S_T2,
        S_DONE
    } state_t;

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_cnt_nxt;
    logic        r_we;
    logic        r_m1;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_busy;
    logic        r_ack;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic [7:0]  r_rdata;
    logic [6:0]  r_rcnt;

    logic        w_start;
    logic        w_we_nxt;
    logic        w_m1_nxt;
    logic [15:0] w_mem_addr_nxt;
    logic [7:0]  w_mem_wdata_nxt;
    logic        w_busy_nxt;
    logic        w_ack_nxt;
    logic        w_mem_rd_nxt;
    logic        w_mem_wr_nxt;
    logic [7:0]  w_rdata_nxt;
    logic [6:0]  w_rcnt_nxt;

    assign w_start = (r_state == S_IDLE) && bus.req;

    // Next-state logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_state_nxt    = S_T1;
                    w_wait_cnt_nxt = WS_LOAD;
                end
            end
            S_T1:   w_state_nxt = (r_wait_cnt != 4'd0) ? S_TW : S_T2;
            S_TW: begin
                w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                if (r_wait_cnt == 4'd1) w_state_nxt = S_T2;
            end
            S_T2:   w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: outputs are decoded from the *next* state and then registered, so every
    // output is a flop yet still lines up with the state it belongs to.
    always_comb begin
        w_we_nxt        = w_start ? bus.we    : r_we;
        w_m1_nxt        = w_start ? bus.m1    : r_m1;
        w_mem_addr_nxt  = w_start ? bus.addr  : r_mem_addr;
        w_mem_wdata_nxt = w_start ? bus.wdata : r_mem_wdata;
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_ack_nxt       = (w_state_nxt == S_DONE);
        w_mem_rd_nxt    = !w_we_nxt &&
                          ((w_state_nxt == S_T1) || (w_state_nxt == S_TW) || (w_state_nxt == S_T2));
        w_mem_wr_nxt    = w_we_nxt && (w_state_nxt == S_T2);
        w_rdata_nxt     = ((r_state == S_T2) && !r_we) ? bus.mem_rdata : r_rdata;
        w_rcnt_nxt      = ((r_state == S_DONE) && !r_we && r_m1) ? r_rcnt + 7'd1 : r_rcnt;
    end

    // NOTE: reset is synchronous; a write strobe already high in T2 is still sampled
    // by the memory on the same edge that clears it here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 4'd0;
            r_we        <= 1'b0;
            r_m1        <= 1'b0;
            r_mem_addr  <= 16'd0;
            r_mem_wdata <= 8'd0;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_rdata     <= 8'd0;
            r_rcnt      <= 7'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_we        <= w_we_nxt;
            r_m1        <= w_m1_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_busy      <= w_busy_nxt;
            r_ack       <= w_ack_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_rdata     <= w_rdata_nxt;
            r_rcnt      <= w_rcnt_nxt;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.ack       = r_ack;
    assign bus.rdata     = r_rdata;
    assign bus.r_reg     = r_rcnt;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;

    a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_mem_rd && r_mem_wr));
    a_wr_only_in_t2: assert property (@(posedge clk) disable iff (!rst_n)
        r_mem_wr |-> (r_state == S_T2));
endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench: two mem_master instances (0 and 3 wait states) against a
// transaction-level timing/data model, with directed reset and handshake scenarios.
module tb_mem_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n_q [2];
    logic        req_q   [2];
    logic        we_q    [2];
    logic        m1_q    [2];
    logic [15:0] addr_q  [2];
    logic [7:0]  wdata_q [2];
    logic [7:0]  mrdata_q[2];
    logic        busy_w  [2];
    logic        ack_w   [2];
    logic        mrd_w   [2];
    logic        mwr_w   [2];
    logic [7:0]  rdata_w [2];
    logic [7:0]  mwd_w   [2];
    logic [6:0]  rreg_w  [2];
    logic [15:0] maddr_w [2];
    bit          cmp_en  [2];

    mem_master_if if0 ();
    mem_master_if if3 ();

    assign if0.req = req_q[0];   assign if3.req = req_q[1];
    assign if0.we = we_q[0];     assign if3.we = we_q[1];
    assign if0.m1 = m1_q[0];     assign if3.m1 = m1_q[1];
    assign if0.addr = addr_q[0]; assign if3.addr = addr_q[1];
    assign if0.wdata = wdata_q[0];     assign if3.wdata = wdata_q[1];
    assign if0.mem_rdata = mrdata_q[0]; assign if3.mem_rdata = mrdata_q[1];
    assign busy_w[0] = if0.busy;      assign busy_w[1] = if3.busy;
    assign ack_w[0] = if0.ack;        assign ack_w[1] = if3.ack;
    assign mrd_w[0] = if0.mem_rd;     assign mrd_w[1] = if3.mem_rd;
    assign mwr_w[0] = if0.mem_wr;     assign mwr_w[1] = if3.mem_wr;
    assign rdata_w[0] = if0.rdata;    assign rdata_w[1] = if3.rdata;
    assign mwd_w[0] = if0.mem_wdata;  assign mwd_w[1] = if3.mem_wdata;
    assign rreg_w[0] = if0.r_reg;     assign rreg_w[1] = if3.r_reg;
    assign maddr_w[0] = if0.mem_addr; assign maddr_w[1] = if3.mem_addr;

    mem_master #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n_q[0]), .bus(if0));
    mem_master #(.WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst_n_q[1]), .bus(if3));

    function automatic int ws_of(int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Power-up memory contents: unwritten bytes read as this pattern (0x0000 -> 0x3E).
    function automatic logic [7:0] dflt(logic [15:0] a);
        return (a[7:0] ^ a[15:8]) + 8'h3E;
    endfunction

    // Synchronous memory: registered read data, write on the edge the strobe is high.
    logic [7:0] mem  [2][65536];
    bit         wr_v [2][65536];

    function automatic logic [7:0] peek(int d, logic [15:0] a);
        return wr_v[d][a] ? mem[d][a] : dflt(a);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mrd_w[d]) mrdata_q[d] <= peek(d, maddr_w[d]);
            if (mwr_w[d]) begin
                mem[d][maddr_w[d]]  <= mwd_w[d];
                wr_v[d][maddr_w[d]] <= 1'b1;
            end
        end
    end

    // Transaction-level reference: one outstanding transfer per instance, with
    // output timing derived from its start cycle (T1) and the wait-state count.
    typedef struct {
        bit          active;
        int          t0;
        bit          we;
        bit          m1;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rd_new;
        logic [7:0]  rd_prev;
        logic [6:0]  rr_prev;
        logic [15:0] a_prev;
        logic [7:0]  old_val;
        bit          old_vld;
    } txn_t;

    txn_t       mdl      [2];
    logic [7:0] shadow   [2][65536];
    bit         sh_v     [2][65536];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_now(input int d, output bit busy, output bit ack,
                                       output bit mrd, output bit mwr,
                                       output logic [15:0] maddr, output logic [7:0] rdata,
                                       output logic [6:0] rreg);
        int k  = cyc - mdl[d].t0;
        int w  = ws_of(d);
        bit on = mdl[d].active && (k >= 0);
        busy  = on && (k <= w + 2);
        ack   = on && (k == w + 2);
        mrd   = on && !mdl[d].we && (k <= w + 1);
        mwr   = on && mdl[d].we && (k == w + 1);
        maddr = on ? mdl[d].addr : mdl[d].a_prev;
        rdata = (on && !mdl[d].we && (k >= w + 2)) ? mdl[d].rd_new : mdl[d].rd_prev;
        rreg  = (on && !mdl[d].we && mdl[d].m1 && (k >= w + 3)) ? mdl[d].rr_prev + 7'd1
                                                                 : mdl[d].rr_prev;
    endfunction

    function automatic void model_start(int d, bit we, bit m1, logic [15:0] a, logic [7:0] wd);
        bit b, ak, rd, wr;
        logic [15:0] ma;
        logic [7:0]  rv;
        logic [6:0]  rr;
        expect_now(d, b, ak, rd, wr, ma, rv, rr);
        mdl[d].a_prev  = ma;
        mdl[d].rd_prev = rv;
        mdl[d].rr_prev = rr;
        mdl[d].active  = 1'b1;
        mdl[d].t0      = cyc + 1;
        mdl[d].we      = we;
        mdl[d].m1      = m1;
        mdl[d].addr    = a;
        mdl[d].wdata   = wd;
        mdl[d].old_val = shadow[d][a];
        mdl[d].old_vld = sh_v[d][a];
        if (we) begin
            shadow[d][a] = wd;
            sh_v[d][a]   = 1'b1;
        end else begin
            mdl[d].rd_new = sh_v[d][a] ? shadow[d][a] : dflt(a);
        end
    endfunction

    // Reset returns everything to zero; an aborted write is undone unless it committed.
    function automatic void model_reset(int d, bit committed);
        if (mdl[d].active && mdl[d].we && !committed) begin
            shadow[d][mdl[d].addr] = mdl[d].old_val;
            sh_v[d][mdl[d].addr]   = mdl[d].old_vld;
        end
        mdl[d].active  = 1'b0;
        mdl[d].rd_prev = 8'd0;
        mdl[d].rr_prev = 7'd0;
        mdl[d].a_prev  = 16'd0;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cmp_en[d]) begin
                bit b, ak, rd, wr;
                logic [15:0] ma;
                logic [7:0]  rv;
                logic [6:0]  rr;
                expect_now(d, b, ak, rd, wr, ma, rv, rr);
                check($sformatf("d%0d busy", d), busy_w[d], b);
                check($sformatf("d%0d ack", d), ack_w[d], ak);
                check($sformatf("d%0d mem_rd", d), mrd_w[d], rd);
                check($sformatf("d%0d mem_wr", d), mwr_w[d], wr);
                check($sformatf("d%0d mem_addr", d), maddr_w[d], ma);
                check($sformatf("d%0d rdata", d), rdata_w[d], rv);
                check($sformatf("d%0d r_reg", d), rreg_w[d], rr);
                if (wr) check($sformatf("d%0d mem_wdata", d), mwd_w[d], mdl[d].wdata);
            end
        end
    end

    // NOTE: inputs change 1ns after the falling edge, well away from the sampling edge.
    task automatic issue(int d, bit we, bit m1, logic [15:0] a, logic [7:0] wd);
        @(negedge clk); #1;
        we_q[d]    = we;
        m1_q[d]    = m1;
        addr_q[d]  = a;
        wdata_q[d] = wd;
        req_q[d]   = 1'b1;
        model_start(d, we, m1, a, wd);
    endtask

    task automatic wait_ack(int d, bit toggle, bit hold, output int lat, output int rdc, output int wrc);
        lat = 0;
        rdc = 0;
        wrc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk); #1;
            rdc += int'(mrd_w[d]);
            wrc += int'(mwr_w[d]);
            if (ack_w[d]) begin
                lat = i;
                if (!hold) req_q[d] = 1'b0;
                return;
            end
            if (toggle) req_q[d] = 1'($urandom_range(0, 1));
        end
        check($sformatf("d%0d ack_timeout", d), ack_w[d], 1'b1);
        req_q[d] = 1'b0;
    endtask

    task automatic do_xfer(int d, bit we, bit m1, logic [15:0] a, logic [7:0] wd, bit toggle,
                           output int lat, output int rdc, output int wrc);
        issue(d, we, m1, a, wd);
        wait_ack(d, toggle, 1'b0, lat, rdc, wrc);
    endtask

    initial begin
        int lat, rdc, wrc, n_m1, cnt_a, cnt_w, cnt_b;
        for (int d = 0; d < 2; d++) begin
            rst_n_q[d] = 1'b0;
            req_q[d]   = 1'b0;
            we_q[d]    = 1'b0;
            m1_q[d]    = 1'b0;
            addr_q[d]  = 16'd0;
            wdata_q[d] = 8'd0;
            cmp_en[d]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            rst_n_q[d] = 1'b1;
            model_reset(d, 1'b0);
            cmp_en[d] = 1'b1;
        end

        // Reset state after 5 idle cycles.
        repeat (5) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d idle busy", d), busy_w[d], 1'b0);
            check($sformatf("d%0d idle ack", d), ack_w[d], 1'b0);
            check($sformatf("d%0d idle mem_rd", d), mrd_w[d], 1'b0);
            check($sformatf("d%0d idle mem_wr", d), mwr_w[d], 1'b0);
            check($sformatf("d%0d idle r_reg", d), rreg_w[d], 7'd0);
            check($sformatf("d%0d idle rdata", d), rdata_w[d], 8'd0);
        end

        // Zero wait states: write then read back.
        do_xfer(0, 1'b1, 1'b0, 16'h1234, 8'hA5, 1'b0, lat, rdc, wrc);
        check("ws0 write latency", lat, 3);
        check("ws0 write pulses", wrc, 1);
        check("ws0 write committed", peek(0, 16'h1234), 8'hA5);
        do_xfer(0, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, lat, rdc, wrc);
        check("ws0 read latency", lat, 3);
        check("ws0 read rd cycles", rdc, 2);
        check("ws0 read no wr", wrc, 0);
        check("ws0 read data", rdata_w[0], 8'hA5);

        // Three wait states: read preloaded 0x3E from 0x0000.
        do_xfer(1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, lat, rdc, wrc);
        check("ws3 read latency", lat, 6);
        check("ws3 tw cycles", rdc - 2, 3);
        check("ws3 read data", rdata_w[1], 8'h3E);

        // Refresh counter: 130 fetches mixed with non-fetch traffic.
        n_m1 = 0;
        while (n_m1 < 130) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    do_xfer(0, 1'b0, 1'b1, 16'($urandom), 8'h00, 1'b0, lat, rdc, wrc);
                    n_m1++;
                end
                2: do_xfer(0, 1'b0, 1'b0, 16'($urandom), 8'h00, 1'b0, lat, rdc, wrc);
                default: do_xfer(0, 1'b1, 1'b1, 16'($urandom_range(16'h8000, 16'h80FF)),
                                 8'($urandom), 1'b0, lat, rdc, wrc);
            endcase
            check("m1 mix latency", lat, 3);
        end
        repeat (2) @(negedge clk);
        #1;
        check("r_reg wrapped", rreg_w[0], 7'd2);

        // req held through ack: second T1 two cycles after ack.
        issue(0, 1'b0, 1'b0, 16'h00A0, 8'h00);
        wait_ack(0, 1'b0, 1'b1, lat, rdc, wrc);
        check("b2b first latency", lat, 3);
        @(negedge clk); #1;
        check("b2b gap busy", busy_w[0], 1'b0);
        model_start(0, 1'b0, 1'b0, 16'h00A0, 8'h00);
        @(negedge clk); #1;
        check("b2b t1 busy", busy_w[0], 1'b1);
        check("b2b t1 mem_rd", mrd_w[0], 1'b1);
        wait_ack(0, 1'b0, 1'b0, lat, rdc, wrc);
        check("b2b second tail", lat, 2);

        // req toggled while busy: exactly one transfer.
        do_xfer(0, 1'b1, 1'b0, 16'h0300, 8'h11, 1'b1, lat, rdc, wrc);
        check("toggle latency", lat, 3);
        check("toggle wr pulses", wrc, 1);
        cnt_b = 0;
        repeat (6) begin
            @(negedge clk); #1;
            cnt_b += int'(busy_w[0]);
        end
        check("toggle no extra xfer", cnt_b, 0);

        // Reset during TW of a write: no strobe, no ack, memory untouched.
        cmp_en[1] = 1'b0;
        check("pre 0x0100", peek(1, 16'h0100), 8'h3F);
        issue(1, 1'b1, 1'b0, 16'h0100, 8'hC3);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("rst tw busy", busy_w[1], 1'b1);
        rst_n_q[1] = 1'b0;
        req_q[1]   = 1'b0;
        cnt_a = 0; cnt_w = 0; cnt_b = 0;
        repeat (4) begin
            @(negedge clk); #1;
            cnt_a += int'(ack_w[1]);
            cnt_w += int'(mwr_w[1]);
            cnt_b += int'(busy_w[1]);
        end
        check("rst tw no ack", cnt_a, 0);
        check("rst tw no wr", cnt_w, 0);
        check("rst tw idle", cnt_b, 0);
        check("rst tw mem", peek(1, 16'h0100), 8'h3F);
        rst_n_q[1] = 1'b1;
        model_reset(1, 1'b0);

        // Reset during T2 of a write: write commits, no ack, back to idle.
        issue(1, 1'b1, 1'b0, 16'h0200, 8'h5A);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (mwr_w[1]) break;
        end
        check("rst t2 strobe", mwr_w[1], 1'b1);
        rst_n_q[1] = 1'b0;
        req_q[1]   = 1'b0;
        @(negedge clk); #1;
        check("rst t2 busy", busy_w[1], 1'b0);
        check("rst t2 mem_wr", mwr_w[1], 1'b0);
        cnt_a = int'(ack_w[1]);
        repeat (2) begin
            @(negedge clk); #1;
            cnt_a += int'(ack_w[1]);
        end
        check("rst t2 no ack", cnt_a, 0);
        check("rst t2 mem", peek(1, 16'h0200), 8'h5A);
        rst_n_q[1] = 1'b1;
        model_reset(1, 1'b1);
        @(negedge clk); #1;
        cmp_en[1] = 1'b1;

        // Random traffic over a small address window on both instances.
        for (int i = 0; i < 60; i++) begin
            int d = i % 2;
            bit w = 1'($urandom_range(0, 1));
            logic [15:0] a = (i < 8) ? ((i % 4 < 2) ? 16'h0100 : 16'h0200)
                                     : {12'h400, 4'($urandom)};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_xfer(d, w, 1'($urandom_range(0, 1)), a, 8'($urandom),
                    1'($urandom_range(0, 1)), lat, rdc, wrc);
            check($sformatf("rand d%0d latency", d), lat, 3 + ws_of(d));
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
